// File: rtl/bitwise_pkg.sv
// Shared types for the bit-wise logic stage.
//   bitwise_op_e : 3-bit opcode carried on in_op
//   FIFO_DEPTH   : number of result entries buffered by the stage
package bitwise_pkg;

  typedef enum logic [2:0] {
    OP_NOT  = 3'd0,
    OP_AND  = 3'd1,
    OP_OR   = 3'd2,
    OP_XOR  = 3'd3,
    OP_NAND = 3'd4,
    OP_NOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_PASS = 3'd7
  } bitwise_op_e;

  localparam int unsigned FIFO_DEPTH = 2;

endpackage : bitwise_pkg

// File: rtl/bitwise_logic_unit.sv
// Combinational bit-wise evaluator.
// Ports:
//   op : opcode (bitwise_op_e encoding)
//   a  : operand A
//   b  : operand B (unused for NOT and PASS)
//   c  : result
module bitwise_logic_unit
  import bitwise_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] c
);

  always_comb begin
    c = a;
    case (bitwise_op_e'(op))
      OP_NOT:  c = ~a;
      OP_AND:  c = a & b;
      OP_OR:   c = a | b;
      OP_XOR:  c = a ^ b;
      OP_NAND: c = ~(a & b);
      OP_NOR:  c = ~(a | b);
      OP_XNOR: c = ~(a ^ b);
      OP_PASS: c = a;
      default: c = a;
    endcase
  end

endmodule : bitwise_logic_unit

// File: rtl/bitwise_op_stage.sv
// Registered bit-wise logic stage: evaluates the opcode at push time and
// buffers results in a 2-entry FIFO presented over valid/ready.
// Ports:
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready depends only on state)
//   in_op, a, b          : opcode and operands
//   out_valid / out_ready: result handshake
//   c                    : result at FIFO head (last popped value when empty)
//   ops_done             : count of results consumed, wraps
module bitwise_op_stage
  import bitwise_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [N-1:0]     a,
  input  logic [N-1:0]     b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     c,
  output logic [CNT_W-1:0] ops_done
);

  localparam logic [1:0] FULL_CNT = 2'(FIFO_DEPTH);

  logic [N-1:0]     mem [FIFO_DEPTH];
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic [N-1:0]     wr_data;
  logic [N-1:0]     last_pop;
  logic [CNT_W-1:0] ops_cnt;
  logic             push;
  logic             pop;

  bitwise_logic_unit #(.N(N)) u_logic (
    .op (in_op),
    .a  (a),
    .b  (b),
    .c  (wr_data)
  );

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign ops_done  = ops_cnt;

  // Once drained, rd_ptr points at an older slot, so the popped value is
  // kept separately to hold c steady while empty.
  assign c = out_valid ? mem[rd_ptr] : last_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      last_pop <= '0;
      ops_cnt  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        last_pop <= mem[rd_ptr];
        rd_ptr   <= ~rd_ptr;
        ops_cnt  <= ops_cnt + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule : bitwise_op_stage

// File: tb/tb_bitwise_op_stage.sv
module tb_bitwise_op_stage;
  import bitwise_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  c;
  logic [15:0] ops_done;

  int n_chk  = 0;
  int n_pass = 0;

  bitwise_op_stage #(.N(8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .c         (c),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] va, input logic [7:0] vb);
    in_valid = v;
    in_op    = op;
    a        = va;
    b        = vb;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, OP_NOT, 8'h11, 8'h22);

    // 1: reset with in_valid high
    step();
    step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_c",         32'(c),         32'h00);
    chk("rst_ops_done",  32'(ops_done),  32'd0);
    rst = 1'b0;
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("rst_no_push",   32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);

    // 2: single NOT
    drive(1'b1, OP_NOT, 8'hA5, 8'h00);
    step();
    chk("not_valid", 32'(out_valid), 32'd1);
    chk("not_c",     32'(c),         32'h5A);
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("not_ops_done", 32'(ops_done),  32'd1);
    chk("not_drained",  32'(out_valid), 32'd0);
    chk("not_c_hold",   32'(c),         32'h5A);

    // 3: streamed AND / XOR / NAND
    drive(1'b1, OP_AND, 8'hF0, 8'h3C);
    step();
    chk("and_c", 32'(c), 32'h30);
    drive(1'b1, OP_XOR, 8'hF0, 8'h3C);
    step();
    chk("xor_valid", 32'(out_valid), 32'd1);
    chk("xor_c",     32'(c),         32'hCC);
    drive(1'b1, OP_NAND, 8'hF0, 8'h3C);
    step();
    chk("nand_c", 32'(c), 32'hCF);
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("stream_ops_done", 32'(ops_done),  32'd4);
    chk("stream_drained",  32'(out_valid), 32'd0);

    // 4: back-pressure until full
    out_ready = 1'b0;
    drive(1'b1, OP_OR, 8'h0F, 8'hF0);
    step();
    chk("bp1_in_ready", 32'(in_ready), 32'd1);
    chk("bp1_c",        32'(c),        32'hFF);
    drive(1'b1, OP_NOR, 8'h0F, 8'h00);
    step();
    chk("bp2_in_ready", 32'(in_ready), 32'd0);
    chk("bp2_c",        32'(c),        32'hFF);
    drive(1'b1, OP_PASS, 8'h77, 8'h00);
    step();
    chk("bp3_in_ready", 32'(in_ready),  32'd0);
    chk("bp3_c",        32'(c),         32'hFF);
    chk("bp3_valid",    32'(out_valid), 32'd1);
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    out_ready = 1'b1;
    step();
    chk("bp_pop1_c",     32'(c),        32'hF0);
    chk("bp_pop1_ready", 32'(in_ready), 32'd1);
    step();
    chk("bp_pop2_valid", 32'(out_valid), 32'd0);
    chk("bp_pop2_c",     32'(c),         32'hF0);
    chk("bp_ops_done",   32'(ops_done),  32'd6);

    // 5: simultaneous push and pop at count 1
    out_ready = 1'b0;
    drive(1'b1, OP_XNOR, 8'hAA, 8'h0F);
    step();
    chk("pp_head", 32'(c), 32'h5A);
    drive(1'b1, OP_PASS, 8'h3C, 8'h00);
    out_ready = 1'b1;
    step();
    chk("pp_valid",    32'(out_valid), 32'd1);
    chk("pp_c",        32'(c),         32'h3C);
    chk("pp_in_ready", 32'(in_ready),  32'd1);
    chk("pp_ops_done", 32'(ops_done),  32'd7);
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("pp_drained",  32'(out_valid), 32'd0);
    chk("pp_ops_done2", 32'(ops_done), 32'd8);

    // 6: counter wrap, then reset while full
    drive(1'b1, OP_PASS, 8'h99, 8'h00);
    repeat (65527) step();
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("wrap_ffff", 32'(ops_done), 32'hFFFF);
    drive(1'b1, OP_NOT, 8'h0F, 8'h00);
    step();
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();
    chk("wrap_zero", 32'(ops_done), 32'h0000);
    chk("wrap_c",    32'(c),        32'hF0);

    out_ready = 1'b0;
    drive(1'b1, OP_AND, 8'hFF, 8'h81);
    step();
    step();
    chk("full_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b1;
    step();
    chk("rstfull_valid",    32'(out_valid), 32'd0);
    chk("rstfull_c",        32'(c),         32'h00);
    chk("rstfull_ops_done", 32'(ops_done),  32'd0);
    chk("rstfull_in_ready", 32'(in_ready),  32'd1);
    rst = 1'b0;
    drive(1'b0, OP_NOT, 8'h00, 8'h00);
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_bitwise_op_stage
